// File: rtl/svga_pkg.sv
// rtl/svga_pkg.sv - shared SVGA 800x600 constants and line-fetch state type
package svga_pkg;

    localparam int WIDTH          = 800;
    localparam int HEIGHT         = 600;

    // 800x600@60 timing, kept here so the timing generator and fetcher agree
    localparam int H_FRONT        = 40;
    localparam int H_SYNC         = 128;
    localparam int H_BACK         = 88;
    localparam int V_FRONT        = 1;
    localparam int V_SYNC         = 4;
    localparam int V_BACK         = 23;

    localparam int WORDS_PER_LINE = WIDTH / 32;
    localparam int ADDR_W         = 24;
    localparam int WORD_IDX_W     = 5;
    localparam int RAM_DEPTH      = 2 * WORDS_PER_LINE;
    localparam int RAM_ADDR_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Bank 0 occupies entries 0..24, bank 1 entries 25..49.
    function automatic logic [RAM_ADDR_W-1:0] ram_index(input logic bank,
                                                        input logic [WORD_IDX_W-1:0] word);
        return bank ? RAM_ADDR_W'(WORDS_PER_LINE) + RAM_ADDR_W'(word)
                    : RAM_ADDR_W'(word);
    endfunction

endpackage

// File: rtl/svga_line_ram.sv
// rtl/svga_line_ram.sv - two-bank line buffer, sync write port, registered read port
//  video_clk : clock
//  wr_en/wr_addr/wr_data : synchronous write port
//  rd_addr/rd_data       : read port, data one cycle after address
module svga_line_ram
    import svga_pkg::*;
(
    input  logic                  video_clk,
    input  logic                  wr_en,
    input  logic [RAM_ADDR_W-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic [RAM_ADDR_W-1:0] rd_addr,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [RAM_DEPTH];

    always_ff @(posedge video_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // Addresses past the end come from off-screen x; they read as blank.
        if (rd_addr < RAM_ADDR_W'(RAM_DEPTH)) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/svga_line_fetch.sv
// rtl/svga_line_fetch.sv - prefetches line N+1 into a two-bank line RAM while line N is shown
//  video_clk, reset                : clock, synchronous active-high reset
//  fetch_enable, fb_base, frame    : fetch control and frame base address
//  screen_x/y, enable, horizontal_pulse : timing generator inputs
//  mem_req/addr/gnt/rvalid/rdata   : single-outstanding word read port
//  pixel, pixel_en                 : pixel output, two cycles after screen_x/y
//  busy, underrun                  : fetch status
module svga_line_fetch
    import svga_pkg::*;
(
    input  logic              video_clk,
    input  logic              reset,
    input  logic              fetch_enable,
    input  logic [ADDR_W-1:0] fb_base,
    input  logic [10:0]       screen_x,
    input  logic [10:0]       screen_y,
    input  logic              enable,
    input  logic              horizontal_pulse,
    input  logic              frame,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              pixel,
    output logic              pixel_en,
    output logic              busy,
    output logic              underrun
);

    localparam logic signed [10:0] Y_FIRST = -11'sd1;
    localparam logic signed [10:0] Y_LAST  = 11'(HEIGHT - 2);

    fetch_state_t          state, state_next;
    logic [WORD_IDX_W-1:0] word_idx;
    logic [ADDR_W-1:0]     line_addr, line_addr_eff, fetch_base;
    logic                  fetch_bank;
    logic signed [10:0]    y_s;
    logic                  trigger, accept, last_word, ram_we;

    logic [RAM_ADDR_W-1:0] rd_addr;
    logic [31:0]           rd_data;
    logic [4:0]            bit_d1;
    logic                  en_d1;

    assign y_s       = screen_y;
    assign trigger   = horizontal_pulse && fetch_enable && (y_s >= Y_FIRST) && (y_s <= Y_LAST);
    assign accept    = trigger && (state == IDLE);
    assign last_word = (word_idx == WORD_IDX_W'(WORDS_PER_LINE - 1));
    assign busy      = (state != IDLE);
    assign mem_addr  = mem_req ? fetch_base + ADDR_W'(word_idx) : '0;

    // A frame pulse coinciding with a trigger fetches from the new base.
    assign line_addr_eff = frame ? fb_base : line_addr;

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        ram_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_next = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    ram_we = 1'b1;
                    // Dropping fetch_enable abandons the line after the outstanding word lands.
                    if (last_word || !fetch_enable) state_next = IDLE;
                    else                            state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge video_clk) begin
        if (reset) begin
            state      <= IDLE;
            word_idx   <= '0;
            line_addr  <= '0;
            fetch_base <= '0;
            fetch_bank <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                line_addr  <= line_addr_eff + ADDR_W'(WORDS_PER_LINE);
                fetch_base <= line_addr_eff;
                // Line L = screen_y + 1 goes to bank L[0], i.e. the opposite parity of screen_y.
                fetch_bank <= ~screen_y[0];
                word_idx   <= '0;
            end else begin
                line_addr <= line_addr_eff;
                if (ram_we && !last_word) word_idx <= word_idx + 1'b1;
            end
            if (!fetch_enable)               underrun <= 1'b0;
            else if (trigger && state != IDLE) underrun <= 1'b1;
        end
    end

    // Negative x points past the RAM so it reads blank.
    assign rd_addr = screen_x[10] ? RAM_ADDR_W'(RAM_DEPTH)
                                  : ram_index(screen_y[0], screen_x[9:5]);

    svga_line_ram u_line_ram (
        .video_clk (video_clk),
        .wr_en     (ram_we),
        .wr_addr   (ram_index(fetch_bank, word_idx)),
        .wr_data   (mem_rdata),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always_ff @(posedge video_clk) begin
        if (reset) begin
            bit_d1   <= '0;
            en_d1    <= 1'b0;
            pixel    <= 1'b0;
            pixel_en <= 1'b0;
        end else begin
            bit_d1   <= screen_x[4:0];
            en_d1    <= enable;
            pixel_en <= en_d1;
            // Bit 31 is the leftmost pixel, so index 31-x[4:0] == ~x[4:0].
            pixel    <= en_d1 & rd_data[~bit_d1];
        end
    end

endmodule

// File: tb/tb_svga_line_fetch.sv
// tb/tb_svga_line_fetch.sv - self-checking bench for svga_line_fetch
module tb_svga_line_fetch;
    import svga_pkg::*;

    logic              video_clk = 1'b0;
    logic              reset;
    logic              fetch_enable;
    logic [ADDR_W-1:0] fb_base;
    logic [10:0]       screen_x;
    logic [10:0]       screen_y;
    logic              enable;
    logic              horizontal_pulse;
    logic              frame;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              pixel;
    logic              pixel_en;
    logic              busy;
    logic              underrun;

    logic [31:0]       fbmem [0:32767];
    logic [31:0]       bank_word [0:1][0:WORDS_PER_LINE-1];
    logic [ADDR_W-1:0] req_log [$];
    logic [ADDR_W-1:0] slow_base;
    int gnt_delay  = 0;
    int rv_delay   = 0;
    int req_cycles = 0;
    int n_tests    = 0;
    int n_fail     = 0;

    svga_line_fetch dut (
        .video_clk        (video_clk),
        .reset            (reset),
        .fetch_enable     (fetch_enable),
        .fb_base          (fb_base),
        .screen_x         (screen_x),
        .screen_y         (screen_y),
        .enable           (enable),
        .horizontal_pulse (horizontal_pulse),
        .frame            (frame),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .pixel            (pixel),
        .pixel_en         (pixel_en),
        .busy             (busy),
        .underrun         (underrun)
    );

    always #5 video_clk = ~video_clk;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fb_word(input logic [ADDR_W-1:0] a);
        return fbmem[a[14:0]];
    endfunction

    // Memory model: grant after gnt_delay cycles of request, data rv_delay cycles after grant.
    initial begin : responder
        int gcnt;
        int rcnt;
        logic pend;
        logic [ADDR_W-1:0] paddr;
        gcnt = 0; rcnt = 0; pend = 1'b0; paddr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge video_clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_req === 1'b1) req_cycles++;
            if (reset === 1'b1) begin
                pend = 1'b0;
                gcnt = 0;
            end else if (pend) begin
                if (rcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = fb_word(paddr);
                    pend       = 1'b0;
                end else begin
                    rcnt--;
                end
            end else if (mem_req === 1'b1) begin
                if (gcnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    gcnt    = 0;
                    pend    = 1'b1;
                    paddr   = mem_addr;
                    rcnt    = rv_delay;
                    req_log.push_back(mem_addr);
                end else begin
                    gcnt++;
                end
            end else begin
                gcnt = 0;
            end
        end
    end

    task automatic do_frame(input logic [ADDR_W-1:0] base);
        @(negedge video_clk);
        fb_base = base;
        frame   = 1'b1;
        @(negedge video_clk);
        frame   = 1'b0;
    endtask

    task automatic pulse_h(input int y);
        @(negedge video_clk);
        screen_x         = '0;
        screen_y         = 11'(y);
        horizontal_pulse = 1'b1;
        @(negedge video_clk);
        horizontal_pulse = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < limit) begin
            @(negedge video_clk);
            cycles++;
        end
    endtask

    task automatic load_bank(input int bank, input logic [ADDR_W-1:0] base);
        for (int w = 0; w < WORDS_PER_LINE; w++)
            bank_word[bank][w] = fb_word(ADDR_W'(base + ADDR_W'(w)));
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_enable = 1'b0; frame = 1'b0; horizontal_pulse = 1'b0;
        enable = 1'b0; screen_x = '0; screen_y = '0; fb_base = '0;
        repeat (3) @(negedge video_clk);
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        n_tests++; if (pixel !== 1'b0) begin n_fail++; $display("FAIL reset_pixel: got %b want 0", pixel); end
        n_tests++; if (pixel_en !== 1'b0) begin n_fail++; $display("FAIL reset_pixel_en: got %b want 0", pixel_en); end
        @(negedge video_clk);
        reset = 1'b0;
        fetch_enable = 1'b1;
    endtask

    task automatic test_line0_fetch();
        int cyc;
        gnt_delay = 0; rv_delay = 0;
        do_frame(24'h001000);
        req_log.delete();
        pulse_h(-1);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL line0_start_busy: got %b want 1", busy); end
        wait_idle(200, cyc);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL line0_done: busy %b want 0", busy); end
        n_tests++; if (cyc != 50) begin n_fail++; $display("FAIL line0_cycles: got %0d want 50", cyc); end
        n_tests++; if (req_log.size() != 25) begin n_fail++; $display("FAIL line0_req_count: got %0d want 25", req_log.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            n_tests++;
            if (req_log[i] !== 24'h001000 + 24'(i)) begin
                n_fail++; $display("FAIL line0_addr[%0d]: got %h want %h", i, req_log[i], 24'h001000 + 24'(i));
            end
        end
        load_bank(0, 24'h001000);
    endtask

    task automatic test_pixel(input int y, input int n, input bit sweep, input int xmax);
        logic ep_q [$];
        logic ee_q [$];
        int   x_q  [$];
        int   x, xo;
        logic en, ep, ee;
        logic [31:0] w;
        for (int k = 0; k < n + 2; k++) begin
            @(negedge video_clk);
            if (k >= 2) begin
                ee = ee_q.pop_front();
                ep = ep_q.pop_front();
                xo = x_q.pop_front();
                n_tests++;
                if (pixel_en !== ee || pixel !== ep) begin
                    n_fail++;
                    $display("FAIL pixel y=%0d x=%0d: got pixel=%b en=%b want pixel=%b en=%b",
                             y, xo, pixel, pixel_en, ep, ee);
                end
            end
            if (k < n) begin
                x  = sweep ? k : int'($urandom_range(0, xmax));
                en = (sweep && k < 32) ? 1'b1 : ($urandom_range(0, 3) != 0);
                screen_x = 11'(x);
                screen_y = 11'(y);
                enable   = en;
                w = bank_word[y & 1][x / 32];
                ee_q.push_back(en);
                ep_q.push_back(en ? w[31 - (x % 32)] : 1'b0);
                x_q.push_back(x);
            end else begin
                enable = 1'b0;
            end
        end
    endtask

    task automatic test_address_stepping();
        int cyc;
        logic [ADDR_W-1:0] exp_base;
        do_frame(24'h001000);
        rv_delay = 0;
        for (int y = -1; y <= HEIGHT - 2; y++) begin
            req_log.delete();
            gnt_delay = $urandom_range(0, 1);
            pulse_h(y);
            wait_idle(400, cyc);
            exp_base = ADDR_W'(24'h001000 + (y + 1) * WORDS_PER_LINE);
            n_tests++;
            if (busy !== 1'b0 || req_log.size() != 25) begin
                n_fail++; $display("FAIL step_line%0d_count: busy %b reqs %0d want busy 0 reqs 25", y + 1, busy, req_log.size());
            end
            for (int i = 0; i < req_log.size(); i++) begin
                n_tests++;
                if (req_log[i] !== exp_base + 24'(i)) begin
                    n_fail++; $display("FAIL step_line%0d_addr[%0d]: got %h want %h", y + 1, i, req_log[i], exp_base + 24'(i));
                end
            end
            load_bank((y + 1) & 1, exp_base);
        end
        req_log.delete();
        req_cycles = 0;
        pulse_h(HEIGHT - 1);
        pulse_h(HEIGHT);
        pulse_h(-2);
        repeat (5) @(negedge video_clk);
        n_tests++; if (req_cycles != 0) begin n_fail++; $display("FAIL step_no_req_after_599: got %0d req cycles want 0", req_cycles); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_idle_after_599: busy %b want 0", busy); end
    endtask

    task automatic test_slow_memory();
        int cyc;
        logic [ADDR_W-1:0] first;
        slow_base = ADDR_W'($urandom);
        do_frame(slow_base);
        gnt_delay = 60; rv_delay = 0;
        req_log.delete();
        pulse_h(-1);
        repeat (100) @(negedge video_clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL slow_busy: got %b want 1", busy); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL slow_underrun_before: got %b want 0", underrun); end
        pulse_h(0);
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL slow_underrun_set: got %b want 1", underrun); end
        wait_idle(3000, cyc);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL slow_done: busy %b want 0", busy); end
        n_tests++; if (req_log.size() != 25) begin n_fail++; $display("FAIL slow_req_count: got %0d want 25", req_log.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            n_tests++;
            if (req_log[i] !== slow_base + 24'(i)) begin
                n_fail++; $display("FAIL slow_addr[%0d]: got %h want %h", i, req_log[i], slow_base + 24'(i));
            end
        end
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL slow_underrun_sticky: got %b want 1", underrun); end
        load_bank(0, slow_base);
        gnt_delay = 0;
        req_log.delete();
        pulse_h(0);
        wait_idle(200, cyc);
        first = (req_log.size() > 0) ? req_log[0] : 'x;
        n_tests++; if (req_log.size() != 25) begin n_fail++; $display("FAIL slow_next_count: got %0d want 25", req_log.size()); end
        n_tests++; if (first !== slow_base + 24'(WORDS_PER_LINE)) begin n_fail++; $display("FAIL slow_next_base: got %h want %h", first, slow_base + 24'(WORDS_PER_LINE)); end
        load_bank(1, slow_base + 24'(WORDS_PER_LINE));
    endtask

    task automatic test_enable_drop();
        int cyc;
        logic [ADDR_W-1:0] lb;
        gnt_delay = 0; rv_delay = 5;
        req_log.delete();
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL drop_underrun_before: got %b want 1", underrun); end
        pulse_h(1);
        cyc = 0;
        while (req_log.size() < 2 && cyc < 100) begin
            @(negedge video_clk);
            cyc++;
        end
        @(negedge video_clk);
        fetch_enable = 1'b0;
        @(negedge video_clk);
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL drop_underrun_cleared: got %b want 0", underrun); end
        wait_idle(50, cyc);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: busy %b want 0", busy); end
        n_tests++; if (req_log.size() != 2) begin n_fail++; $display("FAIL drop_req_count: got %0d want 2", req_log.size()); end
        req_cycles = 0;
        repeat (20) @(negedge video_clk);
        pulse_h(5);
        repeat (3) @(negedge video_clk);
        n_tests++; if (req_cycles != 0) begin n_fail++; $display("FAIL drop_no_more_req: got %0d req cycles want 0", req_cycles); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_no_trigger: busy %b want 0", busy); end
        lb = slow_base + 24'(2 * WORDS_PER_LINE);
        bank_word[0][0] = fb_word(lb);
        bank_word[0][1] = fb_word(lb + 24'd1);
        test_pixel(0, 60, 1'b0, 63);
        rv_delay = 0;
        fetch_enable = 1'b1;
    endtask

    task automatic test_wrap();
        int cyc;
        gnt_delay = 0; rv_delay = 0;
        do_frame(24'hFFFFF0);
        req_log.delete();
        pulse_h(-1);
        wait_idle(200, cyc);
        n_tests++; if (req_log.size() != 25) begin n_fail++; $display("FAIL wrap_req_count: got %0d want 25", req_log.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            n_tests++;
            if (req_log[i] !== 24'hFFFFF0 + 24'(i)) begin
                n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, req_log[i], 24'hFFFFF0 + 24'(i));
            end
        end
        load_bank(0, 24'hFFFFF0);
    endtask

    task automatic test_reset_mid();
        int cyc, px;
        logic [31:0] w;
        logic exp_pix;
        logic [ADDR_W-1:0] first;
        px = 0;
        for (int x = WIDTH - 1; x >= 0; x--) begin
            w = bank_word[0][x / 32];
            if (w[31 - (x % 32)]) px = x;
        end
        w = bank_word[0][px / 32];
        exp_pix = w[31 - (px % 32)];
        gnt_delay = 10;
        pulse_h(3);
        pulse_h(4);
        screen_x = 11'(px);
        screen_y = 11'd0;
        enable   = 1'b1;
        repeat (2) @(negedge video_clk);
        n_tests++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_req: mem_req %b want 1", mem_req); end
        n_tests++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL rstmid_underrun_before: got %b want 1", underrun); end
        n_tests++; if (pixel !== exp_pix) begin n_fail++; $display("FAIL rstmid_pixel_before: got %b want %b", pixel, exp_pix); end
        reset = 1'b1;
        @(negedge video_clk);
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_mem_req: got %b want 0", mem_req); end
        n_tests++; if (mem_addr !== '0) begin n_fail++; $display("FAIL rstmid_mem_addr: got %h want 0", mem_addr); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_tests++; if (pixel !== 1'b0) begin n_fail++; $display("FAIL rstmid_pixel: got %b want 0", pixel); end
        n_tests++; if (pixel_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_pixel_en: got %b want 0", pixel_en); end
        n_tests++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_underrun: got %b want 0", underrun); end
        reset  = 1'b0;
        enable = 1'b0;
        gnt_delay = 0;
        req_log.delete();
        pulse_h(-1);
        wait_idle(200, cyc);
        first = (req_log.size() > 0) ? req_log[0] : 'x;
        n_tests++; if (req_log.size() != 25) begin n_fail++; $display("FAIL rstmid_refetch_count: got %0d want 25", req_log.size()); end
        n_tests++; if (first !== 24'h000000) begin n_fail++; $display("FAIL rstmid_line_addr_cleared: got %h want 000000", first); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) fbmem[i] = $urandom;
        fbmem[15'h1000] = 32'h8000_0001;
        for (int b = 0; b < 2; b++)
            for (int w = 0; w < WORDS_PER_LINE; w++) bank_word[b][w] = '0;
        test_reset();
        test_line0_fetch();
        test_pixel(0, WIDTH, 1'b1, WIDTH - 1);
        test_address_stepping();
        test_pixel(HEIGHT - 1, 200, 1'b0, WIDTH - 1);
        test_slow_memory();
        test_enable_drop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
